// File: rtl/counter_mon_pkg.sv
// Shared types and constants for the counter progress monitor.
package counter_mon_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_TRACK = 2'd1;
    localparam logic [1:0] ENC_FAULT = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ENC_IDLE,
        TRACK = ENC_TRACK,
        FAULT = ENC_FAULT
    } mon_state_e;

    localparam int DEFAULT_STUCK_LIMIT = 3;
    localparam int DEFAULT_ERR_W       = 8;

endpackage

// File: rtl/mon_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module mon_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next value: clear dominates, otherwise step up unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/counter_progress_monitor.sv
// Passive checker for a free-running up-counter: flags stuck and skipped values,
// keeps sticky flags and a saturating error count.
module counter_progress_monitor
    import counter_mon_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int STUCK_LIMIT = DEFAULT_STUCK_LIMIT,
    parameter int ERR_W       = DEFAULT_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] last_count,
    output logic             stuck,
    output logic             skip,
    output logic             fault,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    // The stuck-run counter only needs to reach STUCK_LIMIT, which is at most 15.
    localparam logic [3:0] RUN_LIMIT = 4'(STUCK_LIMIT);

    mon_state_e       state_q,     state_d;
    logic [WIDTH-1:0] lastCount_q, lastCount_d;
    logic             stuck_q,     stuck_d;
    logic             skip_q,      skip_d;
    logic             fault_q,     fault_d;
    logic [3:0]       stuckRun_q,  stuckRun_d;
    logic [WIDTH-1:0] expected;
    logic             errHit;

    assign expected = lastCount_q + WIDTH'(1);

    // Next-state decode: clear beats everything, IDLE waits for the first enabled
    // sample, TRACK and FAULT run identical checks against the previous sample.
    always_comb begin
        state_d     = state_q;
        lastCount_d = count_in;
        stuck_d     = stuck_q;
        skip_d      = skip_q;
        stuckRun_d  = stuckRun_q;
        errHit      = 1'b0;
        if (clr_err) begin
            state_d    = IDLE;
            stuck_d    = 1'b0;
            skip_d     = 1'b0;
            stuckRun_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d = TRACK;
                    end
                end
                TRACK, FAULT: begin
                    if (en && (count_in == expected)) begin
                        stuckRun_d = '0;
                    end else if (en && (count_in == lastCount_q)) begin
                        if ((stuckRun_q + 4'd1) == RUN_LIMIT) begin
                            stuck_d    = 1'b1;
                            errHit     = 1'b1;
                            stuckRun_d = '0;
                        end else begin
                            stuckRun_d = stuckRun_q + 4'd1;
                        end
                    end else if (en || (count_in != lastCount_q)) begin
                        skip_d     = 1'b1;
                        errHit     = 1'b1;
                        stuckRun_d = '0;
                    end
                    if (errHit) begin
                        state_d = FAULT;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    stuckRun_d = '0;
                end
            endcase
        end
        fault_d = stuck_d | skip_d;
    end

    // State and tracking registers; reset is asynchronous and takes effect at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lastCount_q <= '0;
            stuck_q     <= 1'b0;
            skip_q      <= 1'b0;
            fault_q     <= 1'b0;
            stuckRun_q  <= '0;
        end else begin
            state_q     <= state_d;
            lastCount_q <= lastCount_d;
            stuck_q     <= stuck_d;
            skip_q      <= skip_d;
            fault_q     <= fault_d;
            stuckRun_q  <= stuckRun_d;
        end
    end

    mon_sat_counter #(
        .W (ERR_W)
    ) u_errCounter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr_err),
        .inc_i   (errHit),
        .count_o (err_count)
    );

    assign last_count = lastCount_q;
    assign stuck      = stuck_q;
    assign skip       = skip_q;
    assign fault      = fault_q;
    assign state      = state_q;

endmodule

// File: tb/tb_counter_progress_monitor.sv
// Self-checking bench for counter_progress_monitor: directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_counter_progress_monitor;

    localparam int LIMIT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr_err;
    logic [3:0] count_in;

    logic [3:0] last_count, last2;
    logic       stuck, skip, fault, stuck2, skip2, fault2;
    logic [7:0] err_count;
    logic [1:0] err2;
    logic [1:0] state, state2;

    int checks   = 0;
    int failures = 0;

    int mState, mLast, mStuck, mSkip, mErr, mRun;

    typedef struct {
        logic       en;
        logic [3:0] cnt;
        logic       clr;
        int         expState;
        int         expStuck;
        int         expSkip;
        int         expErr;
    } vec_t;

    vec_t vecs[$];

    counter_progress_monitor #(.WIDTH(4), .STUCK_LIMIT(LIMIT), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clr_err(clr_err),
        .last_count(last_count), .stuck(stuck), .skip(skip), .fault(fault),
        .err_count(err_count), .state(state)
    );

    counter_progress_monitor #(.WIDTH(4), .STUCK_LIMIT(LIMIT), .ERR_W(2)) dutSat (
        .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clr_err(clr_err),
        .last_count(last2), .stuck(stuck2), .skip(skip2), .fault(fault2),
        .err_count(err2), .state(state2)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    function automatic void addRow(input logic e, input logic [3:0] c, input logic cl,
                                   input int st, input int sk, input int sp, input int er);
        vec_t v;
        v.en = e; v.cnt = c; v.clr = cl;
        v.expState = st; v.expStuck = sk; v.expSkip = sp; v.expErr = er;
        vecs.push_back(v);
    endfunction

    function automatic int satVal(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Reference behaviour of one clock edge, expressed with plain integers.
    task automatic modelStep(input logic e, input logic [3:0] c, input logic cl);
        int prev;
        bit hit;
        prev  = mLast;
        mLast = int'(c);
        hit   = 1'b0;
        if (cl) begin
            mState = 0; mStuck = 0; mSkip = 0; mErr = 0; mRun = 0;
        end else if (mState == 0) begin
            if (e) mState = 1;
        end else begin
            if (e && mLast == (prev + 1) % 16) begin
                mRun = 0;
            end else if (e && mLast == prev) begin
                mRun++;
                if (mRun == LIMIT) begin
                    mStuck = 1; hit = 1'b1; mRun = 0;
                end
            end else if (e || mLast != prev) begin
                mSkip = 1; hit = 1'b1; mRun = 0;
            end
            if (hit) begin
                mErr++;
                mState = 2;
            end
        end
    endtask

    task automatic modelReset();
        mState = 0; mLast = 0; mStuck = 0; mSkip = 0; mErr = 0; mRun = 0;
    endtask

    task automatic applyStimulus(input logic e, input logic [3:0] c, input logic cl);
        @(negedge clk);
        en = e; count_in = c; clr_err = cl;
        @(posedge clk);
        #1;
        modelStep(e, c, cl);
    endtask

    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, ".state"}, int'(state), mState);
        checkOutput({tag, ".last"},  int'(last_count), mLast);
        checkOutput({tag, ".stuck"}, int'(stuck), mStuck);
        checkOutput({tag, ".skip"},  int'(skip), mSkip);
        checkOutput({tag, ".fault"}, int'(fault), (mStuck | mSkip) != 0 ? 1 : 0);
        checkOutput({tag, ".err"},   int'(err_count), satVal(mErr, 255));
        checkOutput({tag, ".err2"},  int'(err2), satVal(mErr, 3));
        checkOutput({tag, ".state2"}, int'(state2), mState);
        checkOutput({tag, ".fault2"}, int'(fault2), int'(stuck2 | skip2));
        checkOutput({tag, ".last2"}, int'(last2), mLast);
    endtask

    initial begin
        int   r;
        logic e, cl;
        logic [3:0] c;

        // Healthy counter with wrap, then stuck, clear-vs-skip, skip, disabled change.
        for (int i = 0; i < 18; i++) addRow(1'b1, 4'(i % 16), 1'b0, 1, 0, 0, 0);
        for (int i = 1; i <= 12; i++)
            addRow(1'b1, 4'd1, 1'b0, (i >= 3) ? 2 : 1, (i >= 3) ? 1 : 0, 0, i / 3);
        addRow(1'b1, 4'd5, 1'b1, 0, 0, 0, 0);
        addRow(1'b1, 4'd3, 1'b0, 1, 0, 0, 0);
        addRow(1'b1, 4'd4, 1'b0, 1, 0, 0, 0);
        addRow(1'b1, 4'd6, 1'b0, 2, 0, 1, 1);
        addRow(1'b1, 4'd7, 1'b0, 2, 0, 1, 1);
        addRow(1'b1, 4'd8, 1'b0, 2, 0, 1, 1);
        addRow(1'b0, 4'd8, 1'b1, 0, 0, 0, 0);
        addRow(1'b1, 4'd5, 1'b0, 1, 0, 0, 0);
        addRow(1'b0, 4'd5, 1'b0, 1, 0, 0, 0);
        addRow(1'b0, 4'd6, 1'b0, 2, 0, 1, 1);
        addRow(1'b0, 4'd6, 1'b1, 0, 0, 0, 0);
        addRow(1'b1, 4'd2, 1'b0, 1, 0, 0, 0);
        addRow(1'b1, 4'd2, 1'b0, 1, 0, 0, 0);
        addRow(1'b0, 4'd2, 1'b0, 1, 0, 0, 0);
        addRow(1'b1, 4'd2, 1'b0, 1, 0, 0, 0);
        addRow(1'b1, 4'd2, 1'b0, 2, 1, 0, 1);

        rst = 1'b1; en = 1'b0; clr_err = 1'b0; count_in = 4'd0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.state", int'(state), 0);
        checkOutput("reset.last",  int'(last_count), 0);
        checkOutput("reset.flags", int'({stuck, skip, fault}), 0);
        checkOutput("reset.err",   int'(err_count), 0);
        rst = 1'b0;

        $display("[TB] directed vectors: %0d rows", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].cnt, vecs[i].clr);
            checkOutput($sformatf("vec%0d.state", i), int'(state), vecs[i].expState);
            checkOutput($sformatf("vec%0d.last", i),  int'(last_count), int'(vecs[i].cnt));
            checkOutput($sformatf("vec%0d.stuck", i), int'(stuck), vecs[i].expStuck);
            checkOutput($sformatf("vec%0d.skip", i),  int'(skip), vecs[i].expSkip);
            checkOutput($sformatf("vec%0d.fault", i), int'(fault),
                        (vecs[i].expStuck | vecs[i].expSkip) != 0 ? 1 : 0);
            checkOutput($sformatf("vec%0d.err", i),   int'(err_count), vecs[i].expErr);
            checkOutput($sformatf("vec%0d.err2", i),  int'(err2), satVal(vecs[i].expErr, 3));
        end

        // Asynchronous reset in the middle of TRACK, away from any clock edge.
        applyStimulus(1'b0, 4'd3, 1'b1);
        applyStimulus(1'b1, 4'd4, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b0);
        checkOutput("preRst.state", int'(state), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRst.state", int'(state), 0);
        checkOutput("asyncRst.last",  int'(last_count), 0);
        en = 1'b0; count_in = 4'd0; clr_err = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous reset while in FAULT clears flags and the error count.
        applyStimulus(1'b1, 4'd0, 1'b0);
        applyStimulus(1'b1, 4'd9, 1'b0);
        checkOutput("preRst2.err", int'(err_count), 1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("asyncRst2.state", int'(state), 0);
        checkOutput("asyncRst2.flags", int'({stuck, skip, fault}), 0);
        checkOutput("asyncRst2.err",   int'(err_count), 0);
        en = 1'b0; count_in = 4'd0; clr_err = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Continuous skip stream: the 2-bit counter must stop at 3.
        applyStimulus(1'b1, 4'd0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 4'(2 * i), 1'b0);
            checkOutput($sformatf("sat%0d.err", i),  int'(err_count), i);
            checkOutput($sformatf("sat%0d.err2", i), int'(err2), satVal(i, 3));
        end
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkAgainstModel("satClr");

        // Randomized traffic biased toward healthy counting, holds and occasional clears.
        for (int n = 0; n < 500; n++) begin
            r  = int'($urandom_range(0, 99));
            e  = ($urandom_range(0, 3) != 0);
            if (r < 60)      c = 4'(mLast + 1);
            else if (r < 80) c = 4'(mLast);
            else             c = 4'($urandom_range(0, 15));
            cl = ($urandom_range(0, 99) < 3);
            applyStimulus(e, c, cl);
            checkAgainstModel($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_progress_monitor.md
Name: counter_progress_monitor

Overview:
Passive checker that sits on the output bus of a free-running up-counter and verifies its progression every clock. It flags a counter that fails to advance (stuck) and one that jumps to an unexpected value (skip). It keeps sticky fault flags and a saturating error count for benches and on-chip debug. It is the observing end of the counter interface and never drives the counter.

Parameters:
WIDTH, 4, width of the observed count bus
STUCK_LIMIT, 3, consecutive enabled non-advancing samples that constitute one stuck error; legal range 1..15
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock; all sampling on rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  counter is expected to advance at this edge
count_in  input  WIDTH  observed counter value
clr_err  input  1  synchronous clear of flags, counters and tracking; returns to IDLE
last_count  output  WIDTH  count_in captured at the previous edge
stuck  output  1  sticky: a stuck error has occurred
skip  output  1  sticky: a skip or unexpected-change error has occurred
fault  output  1  stuck | skip (registered)
err_count  output  ERR_W  number of errors, saturating at 2^ERR_W-1
state  output  2  current FSM state, debug

Behaviour:
- Reset: state=IDLE; last_count=0; stuck=skip=fault=0; err_count=0; internal stuck_run=0. Reset is honoured at any time, including mid-run or in FAULT.
- Priority at each edge: rst > clr_err > normal operation. If clr_err and an error occur at the same edge, the clear wins: no flag is set and no count is taken.
- All outputs are registered. An error detected at edge k is visible immediately after edge k. There is no further pipeline.
- last_count <= count_in at every edge outside reset, in every state.
- expected = (last_count + 1) mod 2^WIDTH. Wrap-around is legal: last_count=F, count_in=0 is a pass.
- IDLE: no checks. At the first edge with en=1, capture count_in and go to TRACK.
- TRACK and FAULT perform the same checks every edge:
  - en=1, count_in==expected: pass; stuck_run<=0.
  - en=1, count_in==last_count: stuck_run++. When stuck_run reaches STUCK_LIMIT: set stuck, increment err_count, clear stuck_run. A continuously stuck counter therefore logs one error per STUCK_LIMIT samples.
  - en=1, any other value: set skip, increment err_count, stuck_run<=0.
  - en=0, count_in!=last_count: unexpected change; set skip, increment err_count, stuck_run<=0.
  - en=0, count_in==last_count: hold. stuck_run is unchanged.
- Transition TRACK->FAULT occurs at the edge where any error is flagged. FAULT is left only by rst or clr_err, both of which go to IDLE.
- err_count saturates: it holds at all-ones and never wraps.
- fault is the registered OR of the next-state values of stuck and skip, so it asserts on the same edge as the flag.
- State encoding: IDLE=0, TRACK=1, FAULT=2. Value 3 is illegal; the FSM recovers from it to IDLE.

Decomposition:
- Package counter_mon_pkg holds:
  - the state typedef (IDLE/TRACK/FAULT)
  - the 2-bit encoding constants
  - the default STUCK_LIMIT and ERR_W constants
- One sub-module, mon_sat_counter: a parameterised saturating incrementer with synchronous clear, used for err_count. stuck_run is a plain internal counter.

Test Plan:
- Healthy counter: after reset release, en=1 and count_in 0,1,2,…,F,0,1 -> state IDLE->TRACK; stuck=skip=fault=0; err_count=0 throughout, including the F->0 wrap.
- Stuck counter: en=1 and count_in held at 0 for 10 edges after capture -> stuck=1 and fault=1 after the 3rd non-advancing edge; err_count=1, then 2 after 6 edges, then 3 after 9; state=FAULT; skip=0.
- Skip: sequence 3,4,6 with en=1 -> skip=1 at the edge sampling 6; err_count=1; state=FAULT. Then 7,8 -> no further errors.
- Disabled change: en=0 while count_in moves 5->6 -> skip=1, err_count=1. With en=0 and count_in held -> no error and stuck_run unchanged.
- Clear and reset: in FAULT with err_count=4, pulse clr_err coincident with a new skip -> all flags 0, err_count=0, state=IDLE. Assert rst asynchronously mid-TRACK -> outputs reset immediately, without waiting for a clock edge.
- Saturation: ERR_W=2 with a continuous skip stream -> err_count reaches 3 and holds at 3.
